// File: rtl/nt_seq_pkg.sv
// Shared types and polynomial helpers for the subcircuit BIST sequencer:
// FSM state encoding, LFSR/MISR polynomials and their single-step functions.
package nt_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RSTD   = 3'd1,
    S_APPLY  = 3'd2,
    S_SETTLE = 3'd3,
    S_CAPT   = 3'd4,
    S_CHECK  = 3'd5
  } seq_state_t;

  // Fibonacci taps 16,14,13,11 as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  // x^16 + x^12 + x^5 + 1 with the x^16 term implied by the shifted-out MSB
  localparam logic [15:0] MISR_POLY    = 16'h1021;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s);
    return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/nt_misr16.sv
// 16-bit multiple-input signature register; clr restarts the signature,
// en folds din into one polynomial step.
module nt_misr16
  import nt_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] sig
);

  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= 16'h0000;
    end else if (clr) begin
      sig <= 16'h0000;
    end else if (en) begin
      sig <= misr_step(sig) ^ din;
    end
  end

endmodule

// File: rtl/nt_subckt_bist_seq.sv
// BIST sequencer for one gate-level subcircuit: resets it, applies LFSR vectors,
// compacts responses into a MISR and compares against golden_sig.
// Optional macro NTSEQ_ABORT_EN adds an abort input that cancels a run.
//
// Handshake: start is a level request sampled only in IDLE; one accepted start
// produces exactly one run ending with done=1, held until the next accepted
// start or reset. dbg_state mirrors the FSM state register for checkers.
module nt_subckt_bist_seq
  import nt_seq_pkg::*;
#(
  parameter int          IN_W    = 7,
  parameter int          OUT_W   = 1,
  parameter int          PAT_CNT = 256,
  parameter int          SETTLE  = 2,
  parameter int          RST_CYC = 2,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic             I1294_clk,
  input  logic             I1301_rst,
  input  logic             start,
`ifdef NTSEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic [15:0]      golden_sig,
  input  logic [OUT_W-1:0] dut_resp,
  output logic [IN_W-1:0]  dut_stim,
  output logic             dut_rst,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      signature,
  output logic [15:0]      pat_idx,
  output logic [2:0]       dbg_state
);

  // An all-zero LFSR would lock up, so a zero seed falls back to the default
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
  localparam logic [7:0]  RST_LOAD  = 8'(RST_CYC - 1);
  localparam logic [7:0]  SET_LOAD  = 8'(SETTLE - 1);
  localparam logic [15:0] LAST_IDX  = 16'(PAT_CNT - 1);

  seq_state_t  state;
  logic [7:0]  cnt;
  logic [15:0] lfsr;
  logic        abort_req;
  logic        misr_clr;
  logic        misr_en;
  logic [15:0] misr_din;

`ifdef NTSEQ_ABORT_EN
  assign abort_req = abort && (state != S_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign dbg_state = state;
  assign misr_clr  = (state == S_IDLE) && start;
  assign misr_en   = (state == S_CAPT) && !abort_req;

  always_comb begin
    misr_din = 16'h0000;
    misr_din[OUT_W-1:0] = dut_resp;
  end

  always_ff @(posedge I1294_clk) begin
    if (I1301_rst) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      lfsr     <= SEED_EFF;
      pat_idx  <= 16'h0000;
      dut_stim <= '0;
      dut_rst  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else if (abort_req) begin
      // Cancelled run: partial signature stays readable, no verdict is given
      state   <= S_IDLE;
      busy    <= 1'b0;
      dut_rst <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_RSTD;
            lfsr    <= SEED_EFF;
            pat_idx <= 16'h0000;
            done    <= 1'b0;
            pass    <= 1'b0;
            dut_rst <= 1'b1;
            busy    <= 1'b1;
            cnt     <= RST_LOAD;
          end
        end
        S_RSTD: begin
          if (cnt == 8'd0) begin
            dut_rst <= 1'b0;
            state   <= S_APPLY;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_APPLY: begin
          dut_stim <= lfsr[IN_W-1:0];
          lfsr     <= lfsr_step(lfsr);
          cnt      <= SET_LOAD;
          state    <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == 8'd0) begin
            state <= S_CAPT;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_CAPT: begin
          if (pat_idx == LAST_IDX) begin
            state <= S_CHECK;
          end else begin
            pat_idx <= pat_idx + 16'd1;
            state   <= S_APPLY;
          end
        end
        S_CHECK: begin
          pass  <= (signature == golden_sig);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  nt_misr16 u_misr (
    .clk (I1294_clk),
    .rst (I1301_rst),
    .clr (misr_clr),
    .en  (misr_en),
    .din (misr_din),
    .sig (signature)
  );

endmodule
